// File: rtl/alu_issue_pkg.sv
// Shared encodings for the ALU issue controller: MIPS opcode/funct fields, FSM states and
// immediate-extension modes.
package alu_issue_pkg;

  localparam int unsigned DW_DEF  = 32;
  localparam int unsigned RAW_DEF = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_e;

  typedef enum logic [1:0] {ImmSign, ImmZero, ImmBranch} imm_mode_e;

  function automatic logic is_alu_funct(input logic [5:0] fn);
    return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Fetch handshake, regfile ports and ALU ports of the issue controller, bundled as one interface.
interface alu_issue_ctrl_if #(
  parameter int unsigned DW  = alu_issue_pkg::DW_DEF,
  parameter int unsigned RAW = alu_issue_pkg::RAW_DEF
);
  logic           instr_valid;
  logic           instr_ready;
  logic [31:0]    instr;
  logic [RAW-1:0] rf_raddr1;
  logic [RAW-1:0] rf_raddr2;
  logic [DW-1:0]  rf_rdata1;
  logic [DW-1:0]  rf_rdata2;
  logic [5:0]     alu_func;
  logic [5:0]     alu_op;
  logic [DW-1:0]  alu_data_1;
  logic [DW-1:0]  alu_data_2;
  logic [DW-1:0]  alu_result;
  logic           alu_zero;
  logic           rf_we;
  logic [RAW-1:0] rf_waddr;
  logic [DW-1:0]  rf_wdata;
  logic           branch_taken;
  logic [DW-1:0]  branch_offset;
  logic           done;
  logic           illegal;

  modport master (
    input  instr_valid, instr, rf_rdata1, rf_rdata2, alu_result, alu_zero,
    output instr_ready, rf_raddr1, rf_raddr2, alu_func, alu_op, alu_data_1, alu_data_2,
           rf_we, rf_waddr, rf_wdata, branch_taken, branch_offset, done, illegal
  );

  modport slave (
    output instr_valid, instr, rf_rdata1, rf_rdata2, alu_result, alu_zero,
    input  instr_ready, rf_raddr1, rf_raddr2, alu_func, alu_op, alu_data_1, alu_data_2,
           rf_we, rf_waddr, rf_wdata, branch_taken, branch_offset, done, illegal
  );

endinterface

// File: rtl/imm_ext.sv
// Widens a 16-bit immediate: sign-extend, zero-extend, or sign-extend shifted left by two
// (branch word offset).
module imm_ext
  import alu_issue_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic [15:0]   imm,
  input  imm_mode_e     mode,
  output logic [DW-1:0] value
);

  logic [DW-1:0] sext;

  always_comb begin
    sext  = {{(DW-16){imm[15]}}, imm};
    value = sext;
    unique case (mode)
      ImmSign:   value = sext;
      ImmZero:   value = {{(DW-16){1'b0}}, imm};
      ImmBranch: value = {sext[DW-3:0], 2'b00};
      default:   value = sext;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-phase issue controller (IDLE->READ->EXEC->WB): decodes one MIPS instruction, feeds the ALU
// from registered operands and emits a register write-back or beq outcome.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned RAW = RAW_DEF
) (
  input logic             clk,
  input logic             rst_n,
  alu_issue_ctrl_if.master bus
);

  state_e state_q, state_d;

  logic [31:0]    instr_q;
  logic [5:0]     alu_op_q;
  logic [DW-1:0]  alu_d1_q, alu_d2_q;
  logic           rf_we_q;
  logic [RAW-1:0] rf_waddr_q;
  logic [DW-1:0]  rf_wdata_q;
  logic           br_q;
  logic [DW-1:0]  br_off_q;
  logic           done_q;
  logic           illegal_q;

  logic [5:0] op_f, fn_f;
  logic [4:0] rt_f, rd_f;

  logic       dec_legal, dec_wr, dec_beq, dec_use_imm;
  logic [4:0] dec_dest;
  logic [5:0] dec_op;
  imm_mode_e  dec_imm_mode;

  logic [DW-1:0] imm_val;
  logic          wr_en, take;

  assign op_f = instr_q[31:26];
  assign rt_f = instr_q[20:16];
  assign rd_f = instr_q[15:11];
  assign fn_f = instr_q[5:0];

  // I-type arithmetic is folded onto the matching R-type funct so the ALU sees one encoding.
  always_comb begin
    dec_legal    = 1'b0;
    dec_wr       = 1'b0;
    dec_beq      = 1'b0;
    dec_use_imm  = 1'b0;
    dec_dest     = rt_f;
    dec_op       = FN_ADD;
    dec_imm_mode = ImmSign;
    case (op_f)
      OP_RTYPE: begin
        if (is_alu_funct(fn_f)) begin
          dec_legal = 1'b1;
          dec_wr    = 1'b1;
          dec_dest  = rd_f;
          dec_op    = fn_f;
        end
      end
      OP_ADDI: begin
        dec_legal   = 1'b1;
        dec_wr      = 1'b1;
        dec_use_imm = 1'b1;
        dec_op      = FN_ADD;
      end
      OP_ANDI: begin
        dec_legal    = 1'b1;
        dec_wr       = 1'b1;
        dec_use_imm  = 1'b1;
        dec_op       = FN_AND;
        dec_imm_mode = ImmZero;
      end
      OP_ORI: begin
        dec_legal    = 1'b1;
        dec_wr       = 1'b1;
        dec_use_imm  = 1'b1;
        dec_op       = FN_OR;
        dec_imm_mode = ImmZero;
      end
      OP_BEQ: begin
        dec_legal    = 1'b1;
        dec_beq      = 1'b1;
        dec_op       = FN_SUB;
        dec_imm_mode = ImmBranch;
      end
      default: ;
    endcase
  end

  imm_ext #(
    .DW(DW)
  ) u_imm_ext (
    .imm  (instr_q[15:0]),
    .mode (dec_imm_mode),
    .value(imm_val)
  );

  assign wr_en = dec_wr && (dec_dest != 5'd0);
  assign take  = dec_beq && bus.alu_zero;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.instr_valid) state_d = READ;
      READ:    state_d = dec_legal ? EXEC : WB;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= '0;
      alu_op_q   <= '0;
      alu_d1_q   <= '0;
      alu_d2_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      br_q       <= 1'b0;
      br_off_q   <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.instr_valid) instr_q <= bus.instr;
        end
        READ: begin
          if (dec_legal) begin
            alu_op_q <= dec_op;
            alu_d1_q <= bus.rf_rdata1;
            alu_d2_q <= dec_use_imm ? imm_val : bus.rf_rdata2;
          end else begin
            done_q    <= 1'b1;
            illegal_q <= 1'b1;
          end
        end
        EXEC: begin
          alu_op_q   <= '0;
          alu_d1_q   <= '0;
          alu_d2_q   <= '0;
          rf_we_q    <= wr_en;
          rf_waddr_q <= wr_en ? RAW'(dec_dest) : '0;
          rf_wdata_q <= wr_en ? bus.alu_result : '0;
          br_q       <= take;
          br_off_q   <= take ? imm_val : '0;
          done_q     <= 1'b1;
        end
        WB: begin
          rf_we_q    <= 1'b0;
          rf_waddr_q <= '0;
          rf_wdata_q <= '0;
          br_q       <= 1'b0;
          br_off_q   <= '0;
          done_q     <= 1'b0;
          illegal_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.instr_ready   = (state_q == IDLE);
  assign bus.rf_raddr1     = RAW'(instr_q[25:21]);
  assign bus.rf_raddr2     = RAW'(rt_f);
  // Every issued operation is presented to the ALU in R-type form.
  assign bus.alu_func      = OP_RTYPE;
  assign bus.alu_op        = alu_op_q;
  assign bus.alu_data_1    = alu_d1_q;
  assign bus.alu_data_2    = alu_d2_q;
  assign bus.rf_we         = rf_we_q;
  assign bus.rf_waddr      = rf_waddr_q;
  assign bus.rf_wdata      = rf_wdata_q;
  assign bus.branch_taken  = br_q;
  assign bus.branch_offset = br_off_q;
  assign bus.done          = done_q;
  assign bus.illegal       = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed plus randomized bench for alu_issue_ctrl with a behavioural regfile, ALU and
// instruction-level reference model.
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.DW(32), .RAW(5)) bus ();

  alu_issue_ctrl #(
    .DW (32),
    .RAW(5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [31:0] regs [32];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] alu_ref(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    case (f)
      FN_ADD:  return a + b;
      FN_SUB:  return a - b;
      FN_AND:  return a & b;
      FN_OR:   return a | b;
      FN_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign bus.rf_rdata1  = regs[bus.rf_raddr1];
  assign bus.rf_rdata2  = regs[bus.rf_raddr2];
  assign bus.alu_result = alu_ref(bus.alu_op, bus.alu_data_1, bus.alu_data_2);
  assign bus.alu_zero   = (bus.alu_result == 32'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Issue one instruction and check every phase against the instruction-level model.
  task automatic run_instr(input logic [31:0] ins);
    logic [5:0]  op, fn, aop;
    logic [4:0]  rs, rt, rd, dest;
    logic [15:0] imm;
    logic [31:0] a, b, sx, zx, res, sv_rs, sv_rt;
    logic        legal, wr, br, exp_we, exp_taken;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    fn = ins[5:0]; imm = ins[15:0];
    sx = {{16{imm[15]}}, imm};
    zx = {16'd0, imm};
    a = regs[rs]; b = regs[rt];
    legal = 1'b0; wr = 1'b0; br = 1'b0; dest = rt; aop = 6'd0;
    if (op == 6'b000000 && (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                       6'b101010})) begin
      legal = 1'b1; wr = 1'b1; dest = rd; aop = fn;
    end else if (op == 6'b001000) begin
      legal = 1'b1; wr = 1'b1; b = sx; aop = 6'b100000;
    end else if (op == 6'b001100) begin
      legal = 1'b1; wr = 1'b1; b = zx; aop = 6'b100100;
    end else if (op == 6'b001101) begin
      legal = 1'b1; wr = 1'b1; b = zx; aop = 6'b100101;
    end else if (op == 6'b000100) begin
      legal = 1'b1; br = 1'b1; aop = 6'b100010;
    end
    res       = alu_ref(aop, a, b);
    exp_we    = wr && (dest != 5'd0);
    exp_taken = br && (a == b);

    @(negedge clk);
    chk("ready_idle", 32'(bus.instr_ready), 32'd1);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    chk("read_raddr1", 32'(bus.rf_raddr1), 32'(rs));
    chk("read_raddr2", 32'(bus.rf_raddr2), 32'(rt));
    chk("read_ready", 32'(bus.instr_ready), 32'd0);
    @(posedge clk); #1;
    sv_rs = regs[rs]; sv_rt = regs[rt];
    if (legal) begin
      // Operands must already be captured; disturbing the regfile now must not matter.
      regs[rs] = ~sv_rs + 32'h1234;
      regs[rt] = sv_rt ^ 32'h5a5a_0f0f;
      chk("exec_func", 32'(bus.alu_func), 32'd0);
      chk("exec_op", 32'(bus.alu_op), 32'(aop));
      chk("exec_d1", bus.alu_data_1, a);
      chk("exec_d2", bus.alu_data_2, b);
      chk("exec_done", 32'(bus.done), 32'd0);
      chk("exec_ready", 32'(bus.instr_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk("wb_done", 32'(bus.done), 32'd1);
    chk("wb_illegal", 32'(bus.illegal), 32'(!legal));
    chk("wb_we", 32'(bus.rf_we), 32'(exp_we));
    if (exp_we) begin
      chk("wb_waddr", 32'(bus.rf_waddr), 32'(dest));
      chk("wb_wdata", bus.rf_wdata, res);
    end
    chk("wb_taken", 32'(bus.branch_taken), 32'(exp_taken));
    if (exp_taken) chk("wb_offset", bus.branch_offset, {sx[29:0], 2'b00});
    regs[rt] = sv_rt;
    regs[rs] = sv_rs;
    @(posedge clk); #1;
    chk("post_done", 32'(bus.done), 32'd0);
    chk("post_we", 32'(bus.rf_we), 32'd0);
    chk("post_ready", 32'(bus.instr_ready), 32'd1);
  endtask

  initial begin
    logic [5:0] fn_ok  [5];
    logic [5:0] fn_bad [4];
    logic [5:0] op_bad [4];
    logic [4:0] r1, r2, r3;
    logic [15:0] imm;
    fn_ok  = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    fn_bad = '{6'b000000, 6'b100001, 6'b100011, 6'b000010};
    op_bad = '{6'b100011, 6'b101011, 6'b000010, 6'b001010};

    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'd0;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'd0;

    // Reset state
    #12;
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_we", 32'(bus.rf_we), 32'd0);
    chk("rst_op", 32'(bus.alu_op), 32'd0);
    chk("rst_d1", bus.alu_data_1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.instr_ready), 32'd1);

    // Directed cases
    regs[1] = 32'd5; regs[2] = 32'd7;
    run_instr(rtype(5'd1, 5'd2, 5'd3, FN_ADD));
    regs[10] = 32'd10;
    run_instr(itype(OP_ADDI, 5'd10, 5'd4, 16'hFFFF));
    run_instr(itype(OP_ANDI, 5'd10, 5'd4, 16'hFFFF));
    run_instr(itype(OP_ORI, 5'd10, 5'd5, 16'h8001));
    regs[6] = 32'h55; regs[7] = 32'h55;
    run_instr(itype(OP_BEQ, 5'd6, 5'd7, 16'h0003));
    regs[7] = 32'h56;
    run_instr(itype(OP_BEQ, 5'd6, 5'd7, 16'h0003));
    regs[7] = 32'h55;
    run_instr(itype(OP_BEQ, 5'd6, 5'd7, 16'hFFFE));
    run_instr(itype(6'b100011, 5'd1, 5'd2, 16'h0010));
    run_instr(rtype(5'd1, 5'd2, 5'd3, 6'b000000));
    regs[8] = 32'hFFFF_FFFE; regs[9] = 32'd1;
    run_instr(rtype(5'd8, 5'd9, 5'd11, FN_SLT));
    run_instr(rtype(5'd9, 5'd8, 5'd11, FN_SLT));
    run_instr(itype(OP_ADDI, 5'd1, 5'd0, 16'h0001));

    // Back-to-back with valid held high; rd=0 so no write may ever appear
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = rtype(5'd1, 5'd2, 5'd0, FN_ADD);
    for (int i = 0; i < 12; i++) begin
      chk("b2b_ready", 32'(bus.instr_ready), 32'((i % 4) == 0));
      chk("b2b_done", 32'(bus.done), 32'((i % 4) == 3));
      chk("b2b_we", 32'(bus.rf_we), 32'd0);
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_idle", 32'(bus.instr_ready), 32'd1);

    // Reset while in EXEC
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = itype(OP_ADDI, 5'd10, 5'd12, 16'h0002);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("exec_pre_rst_op", 32'(bus.alu_op), 32'(FN_ADD));
    rst_n = 1'b0;
    #1;
    chk("rstx_op", 32'(bus.alu_op), 32'd0);
    chk("rstx_d1", bus.alu_data_1, 32'd0);
    chk("rstx_d2", bus.alu_data_2, 32'd0);
    @(posedge clk); #1;
    chk("rstx_done", 32'(bus.done), 32'd0);
    chk("rstx_we", 32'(bus.rf_we), 32'd0);
    chk("rstx_taken", 32'(bus.branch_taken), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstx_ready", 32'(bus.instr_ready), 32'd1);
    run_instr(itype(OP_ADDI, 5'd10, 5'd12, 16'h0002));

    // Randomized instruction mix
    for (int n = 0; n < 60; n++) begin
      r1 = 5'($urandom_range(0, 31));
      r2 = 5'($urandom_range(0, 31));
      r3 = 5'($urandom_range(0, 31));
      imm = 16'($urandom);
      if ((n % 8) == 0) begin
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
      end
      case ($urandom_range(0, 7))
        0, 7: run_instr(rtype(r1, r2, r3, fn_ok[$urandom_range(0, 4)]));
        1: run_instr(rtype(r1, r2, r3, fn_bad[$urandom_range(0, 3)]));
        2: run_instr(itype(OP_ADDI, r1, r2, imm));
        3: run_instr(itype(OP_ANDI, r1, r2, imm));
        4: run_instr(itype(OP_ORI, r1, r2, imm));
        5: begin
          if ($urandom_range(0, 1) == 1 && r2 != 5'd0) regs[r2] = regs[r1];
          if (r2 == 5'd0 && r1 != 5'd0 && $urandom_range(0, 1) == 1) regs[r1] = 32'd0;
          run_instr(itype(OP_BEQ, r1, r2, imm));
        end
        default: run_instr(itype(op_bad[$urandom_range(0, 3)], r1, r2, imm));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
